// File: rtl/adder_ring_counter.sv
// adder_ring_counter: rising-edge counter for the instrumented adder's ring output.
// The ring signal is synchronised into wb_clk_i, and its rising edges are
// counted over a window of clock cycles given by the window input. The result
// is then presented to the logic analyser mux.
// Optional feature: define ADDER_RING_CNT_SAT_EN to make the accumulator
// saturate and report overflow. When the macro is undefined, the accumulator
// wraps and overflow is tied low.
module adder_ring_counter #(
    parameter int CNT_W  = 32,
    parameter int WIN_W  = 16,
    parameter int SYNC_N = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             active,
    input  logic             start,
    input  logic [WIN_W-1:0] window,
    input  logic             ring_in,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             overflow
);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_COUNT, S_DONE} state_t;

    localparam logic [WIN_W-1:0] SYNC_LEN = WIN_W'(SYNC_N);

    state_t             r_state;
    logic [SYNC_N-1:0]  r_sync;
    logic               r_edge;
    logic [WIN_W-1:0]   r_win;
    logic [WIN_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   w_acc_nxt;
    logic               w_rise;
`ifdef ADDER_RING_CNT_SAT_EN
    logic               r_sat;
    logic               r_ovf;
    logic               w_sat_hit;
`endif

    // Metastability chain on the asynchronous ring input, plus a delayed copy for edge detection
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], ring_in};
            r_edge <= r_sync[SYNC_N-1];
        end
    end

    assign w_rise = r_sync[SYNC_N-1] & ~r_edge;

    // Next accumulator value: either wraps or holds at all-ones, depending on the build
    always_comb begin
        w_acc_nxt = r_acc;
`ifdef ADDER_RING_CNT_SAT_EN
        w_sat_hit = w_rise & (&r_acc);
        if (w_rise && !(&r_acc))
            w_acc_nxt = r_acc + 1'b1;
`else
        w_acc_nxt = r_acc + CNT_W'(w_rise);
`endif
    end

`ifdef ADDER_RING_CNT_SAT_EN
    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

    // Measurement FSM. A single down-counter times both the flush phase and the count window.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_cyc   <= '0;
            r_acc   <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
`ifdef ADDER_RING_CNT_SAT_EN
            r_sat   <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (!active) begin
                // Abort: drop any measurement in flight. The last count is kept.
                r_state <= S_IDLE;
                r_acc   <= '0;
                valid   <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_win   <= window;
                            r_cyc   <= SYNC_LEN;
                            valid   <= 1'b0;
                            busy    <= 1'b1;
                            r_state <= S_SYNC;
`ifdef ADDER_RING_CNT_SAT_EN
                            r_sat   <= 1'b0;
                            r_ovf   <= 1'b0;
`endif
                        end
                    end
                    S_SYNC: begin
                        // Let stale ring history drain out of the synchroniser before counting
                        r_acc <= '0;
                        if (r_cyc == 1) begin
                            r_cyc   <= r_win;
                            r_state <= (r_win == '0) ? S_DONE : S_COUNT;
                        end else begin
                            r_cyc <= r_cyc - 1'b1;
                        end
                    end
                    S_COUNT: begin
                        r_acc <= w_acc_nxt;
`ifdef ADDER_RING_CNT_SAT_EN
                        if (w_sat_hit) r_sat <= 1'b1;
`endif
                        if (r_cyc == 1) r_state <= S_DONE;
                        else            r_cyc   <= r_cyc - 1'b1;
                    end
                    S_DONE: begin
                        count   <= r_acc;
                        done    <= 1'b1;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
`ifdef ADDER_RING_CNT_SAT_EN
                        r_ovf   <= r_sat;
`endif
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adder_ring_counter.sv
// Directed bench for adder_ring_counter. Two instances share the stimulus:
// u0 uses the default 32-bit counter, and u1 uses a 4-bit counter for the wrap/saturate cases.
module tb_adder_ring_counter;

    logic        clk = 1'b0;
    logic        rst, active, start, ring;
    logic [15:0] window;
    logic [31:0] count0;
    logic [3:0]  count1;
    logic        busy0, done0, valid0, ovf0;
    logic        busy1, done1, valid1, ovf1;
    int          ring_half = 1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat, k;

    always #5 clk = ~clk;

    adder_ring_counter u0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start(start),
        .window(window), .ring_in(ring), .count(count0), .busy(busy0),
        .done(done0), .valid(valid0), .overflow(ovf0)
    );

    adder_ring_counter #(.CNT_W(4)) u1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start(start),
        .window(window), .ring_in(ring), .count(count1), .busy(busy1),
        .done(done1), .valid(valid1), .overflow(ovf1)
    );

    // ring toggles every ring_half clocks, changed on the falling edge
    initial begin
        int ph;
        ring = 1'b0;
        ph = 0;
        forever begin
            @(negedge clk);
            if (ring_half > 0) begin
                ph++;
                if (ph >= ring_half) begin
                    ph = 0;
                    ring = ~ring;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // present start for one edge (edge t), return at the falling edge after t
    task automatic launch(input logic [15:0] w);
        @(negedge clk);
        start = 1'b1;
        window = w;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        window = 16'hA5A5;
    endtask

    // cycles after edge t until done is seen (0 = timed out); optional stray start at poke_at
    task automatic wait_done(input int limit, input int poke_at, output int l);
        l = 0;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            @(negedge clk);
            start = (n == poke_at);
            if (done0 && l == 0) begin
                l = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic count_dones(input int cycles, output int d);
        d = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (done0) d++;
        end
    endtask

    initial begin
        rst = 1'b1; active = 1'b0; start = 1'b0; window = 16'd0;

        // reset with ring toggling every cycle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_count", count0, 0);
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_done", {31'd0, done0}, 0);
        chk("rst_valid", {31'd0, valid0}, 0);
        chk("rst_ovf", {31'd0, ovf0}, 0);
        chk("rst_ovf_w4", {31'd0, ovf1}, 0);
        rst = 1'b0;
        active = 1'b1;
        ring_half = 4;
        repeat (20) @(negedge clk);

        // window=64, ring period 8 -> 8 edges, done 67 edges after start
        launch(16'd64);
        chk("t2_busy", {31'd0, busy0}, 1);
        wait_done(200, 0, lat);
        chk("t2_lat", lat, 67);
        chk("t2_count", count0, 8);
        chk("t2_valid", {31'd0, valid0}, 1);
        chk("t2_busy_done", {31'd0, busy0}, 0);
        @(negedge clk);
        chk("t2_done_pulse", {31'd0, done0}, 0);

        // window=0 -> done after the flush phase only, ring ignored
        launch(16'd0);
        chk("t3_valid_clr", {31'd0, valid0}, 0);
        wait_done(50, 0, lat);
        chk("t3_lat", lat, 3);
        chk("t3_count", count0, 0);
        chk("t3_valid", {31'd0, valid0}, 1);

        // stray start during COUNT is ignored
        launch(16'd64);
        wait_done(200, 20, lat);
        chk("t4_lat", lat, 67);
        chk("t4_count", count0, 8);
        count_dones(80, k);
        chk("t4_single_done", k, 0);

        // active dropped mid-COUNT aborts without done and keeps the last count
        launch(16'd64);
        repeat (20) @(negedge clk);
        active = 1'b0;
        @(negedge clk);
        chk("t4_abort_busy", {31'd0, busy0}, 0);
        chk("t4_abort_done", {31'd0, done0}, 0);
        chk("t4_abort_valid", {31'd0, valid0}, 0);
        chk("t4_abort_count", count0, 8);
        count_dones(70, k);
        chk("t4_abort_nodone", k, 0);
        active = 1'b1;

        // ring period 2, window 40 -> 20 edges; 4-bit counter wraps or saturates
        ring_half = 1;
        repeat (10) @(negedge clk);
        launch(16'd40);
        wait_done(200, 0, lat);
        chk("t5_lat", lat, 43);
        chk("t5_count32", count0, 20);
        chk("t5_ovf32", {31'd0, ovf0}, 0);
`ifdef ADDER_RING_CNT_SAT_EN
        chk("t5_count4", {28'd0, count1}, 15);
        chk("t5_ovf4", {31'd0, ovf1}, 1);
`else
        chk("t5_count4", {28'd0, count1}, 4);
        chk("t5_ovf4", {31'd0, ovf1}, 0);
`endif
        launch(16'd0);
        chk("t5_ovf4_clr", {31'd0, ovf1}, 0);
        wait_done(50, 0, lat);
        chk("t5_lat0", lat, 3);

        // one-cycle reset mid-COUNT, then a clean measurement
        ring_half = 4;
        repeat (10) @(negedge clk);
        launch(16'd64);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_count", count0, 0);
        chk("t6_busy", {31'd0, busy0}, 0);
        chk("t6_done", {31'd0, done0}, 0);
        chk("t6_valid", {31'd0, valid0}, 0);
        chk("t6_ovf4", {31'd0, ovf1}, 0);
        repeat (4) @(negedge clk);
        launch(16'd64);
        wait_done(200, 0, lat);
        chk("t6_lat", lat, 67);
        chk("t6_count_after", count0, 8);
        chk("t6_valid_after", {31'd0, valid0}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
